// File: rtl/bootrom_read_bridge.sv
// rtl/bootrom_read_bridge.sv - burst read front-end for the boot mask ROM macro.
// Optional BOOTROM_ACCESS_CNT_EN adds saturating good/error beat counters.
module bootrom_read_bridge #(
  parameter int          ROM_AW    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int          LEN_W     = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_error,
  output logic              resp_last,
  output logic              rom_me,
  output logic              rom_oe,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [31:0]       rom_q
`ifdef BOOTROM_ACCESS_CNT_EN
  ,
  output logic [31:0]       access_cnt,
  output logic [15:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state, state_next;
  logic [31:0]      addr;
  logic [LEN_W:0]   remaining;
  logic             err_all;
  logic             beat_err;
  logic [31:0]      issue_addr;
  logic [31:0]      issue_off;
  logic             issue_good;
  logic             issue_en;

  // In RESP the next beat is issued while the current one is accepted, so it targets addr+4.
  always_comb begin
    issue_addr = (state == RESP) ? addr + 32'd4 : addr;
    issue_off  = issue_addr - BASE_ADDR;
    issue_good = !err_all && (issue_addr >= BASE_ADDR) &&
                 (issue_off[31:ROM_AW+2] == '0) && (issue_off[1:0] == 2'b00);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_error  = 1'b0;
    resp_last   = 1'b0;
    resp_data   = 32'd0;
    rom_me      = 1'b0;
    rom_oe      = 1'b0;
    rom_address = '0;
    issue_en    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: begin
        rom_oe     = 1'b1;
        issue_en   = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rom_oe     = 1'b1;
        resp_valid = 1'b1;
        resp_error = beat_err;
        resp_last  = (remaining == (LEN_W+1)'(1));
        resp_data  = beat_err ? 32'd0 : rom_q;
        if (resp_ready) begin
          if (resp_last) state_next = IDLE;
          else           issue_en   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Holding rom_me low during a stall keeps the macro's output register stable.
    if (issue_en && issue_good) begin
      rom_me      = 1'b1;
      rom_address = issue_off[ROM_AW+1:2];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr      <= 32'd0;
      remaining <= '0;
      err_all   <= 1'b0;
      beat_err  <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr      <= req_addr;
        remaining <= (LEN_W+1)'(req_len) + (LEN_W+1)'(1);
        err_all   <= (req_addr[1:0] != 2'b00);
      end
      if (issue_en) begin
        beat_err <= !issue_good;
        if (state == RESP) begin
          addr      <= issue_addr;
          remaining <= remaining - (LEN_W+1)'(1);
        end
      end
    end
  end

`ifdef BOOTROM_ACCESS_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      access_cnt <= 32'd0;
      err_cnt    <= 16'd0;
    end else if (state == RESP && resp_ready) begin
      if (beat_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else begin
        if (access_cnt != 32'hFFFF_FFFF) access_cnt <= access_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/bootrom_read_bridge.md
Name: bootrom_read_bridge

Overview:
- Upstream request/response front-end for the boot mask ROM macro.
- Accepts byte-addressed read bursts from the system bus and drives the ROM macro's me/oe/address pins.
- Captures the macro's 1-cycle registered output and returns it on a valid/ready response channel.
- Flags misaligned and out-of-range accesses; sustains 1 beat/cycle throughput under full backpressure support.

Parameters:
- ROM_AW, 11, ROM word-address width; depth = 2**ROM_AW 32-bit words.
- BASE_ADDR, 32'h0001_0000, byte address of ROM word 0.
- LEN_W, 3, burst-length field width; burst = req_len+1 beats (1..8).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- req_addr  in  32  byte start address.
- req_len  in  LEN_W  beats minus one.
- resp_valid  out  1  response beat valid.
- resp_ready  in  1  consumer accepts beat.
- resp_data  out  32  ROM word; 0 when !resp_valid or on error beat.
- resp_error  out  1  beat is misaligned/out-of-range.
- resp_last  out  1  final beat of burst.
- rom_me  out  1  ROM macro read enable; one pulse = one word fetch.
- rom_oe  out  1  ROM macro output enable.
- rom_address  out  ROM_AW  ROM word address.
- rom_q  in  32  ROM macro data, valid the cycle after an rom_me pulse.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; req_ready=1, resp_valid=0, resp_error=0, resp_last=0, resp_data=0, rom_me=0, rom_oe=0, rom_address=0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1. On handshake, latch addr, remaining=req_len+1, err_all=(req_addr[1:0]!=0).
  - Go ISSUE.
- ISSUE:
  - req_ready=0.
  - In range (BASE_ADDR <= addr < BASE_ADDR+4*2**ROM_AW) and !err_all: rom_me=1, rom_address=(addr-BASE_ADDR)>>2.
  - Otherwise the beat is an error beat with no rom_me.
  - Go RESP next cycle.
- RESP:
  - resp_valid=1. resp_data=rom_q for good beats, 0 for error beats. resp_error set for error beats. resp_last=(remaining==1).
  - On resp_ready && !resp_last: decrement remaining, addr+=4, and issue the next beat in the same cycle (rom_me per the in-range rule, stay RESP). This gives back-to-back beats.
  - On resp_ready && resp_last: go IDLE. req_ready rises the following cycle.
  - If resp_ready=0: rom_me=0, so the macro's output register holds. resp_data/error/last stay stable until accepted.
- Latency: handshake cycle N; rom_me in N+1; resp_valid in N+2.
- rom_oe=1 in ISSUE and RESP, 0 in IDLE.
- Misaligned start: every beat of the burst is an error beat; rom_me never pulses.
- Range is checked per beat, so a burst crossing the ROM top returns good beats then error beats. Address arithmetic is 32-bit with wrap; a wrapped address is out of range and flagged as an error.
- New requests are ignored while busy (req_ready=0); at most one burst is in flight.
- Reset mid-burst: the burst is aborted at the next posedge; no further rom_me; no partial beats after reset.

Optional Feature:
- Macro: BOOTROM_ACCESS_CNT_EN.
- Defined:
  - Adds output access_cnt[31:0]: saturating count of accepted good (non-error) beats.
  - Adds output err_cnt[15:0]: saturating count of accepted error beats.
  - Both counters reset to 0 on reset_n=0.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Single read, ROM word0=0x00000297, req_addr=0x10000, len=0, resp_ready=1 -> rom_me one cycle with address 0; resp_valid 2 cycles after handshake; data 0x00000297, last=1, error=0.
- Burst req_addr=0x10010, len=3, ROM words 4..7=0xA0..0xA3, resp_ready=1 -> 4 consecutive beats 0xA0,0xA1,0xA2,0xA3; last only on 4th; rom_address 4,5,6,7.
- Same burst with resp_ready low 3 cycles after beat 2 -> rom_me=0 during stall; beat 2 data held stable; beats 3,4 delivered afterwards, none lost or duplicated.
- Misaligned req_addr=0x10002, len=1 -> 2 beats, data 0, error=1, last on 2nd; rom_me never asserted.
- Boundary req_addr=0x11FFC, len=1 -> beat1 = word 2047 with error=0; beat2 error=1, data 0. req_addr=0x0 -> single error beat.
- reset_n=0 for 1 cycle during beat 2 of a 4-beat burst -> next cycle resp_valid=0, rom_me=0, req_ready=1; a following single read completes normally.
